// File: rtl/led_trail_pwm.sv
// led_trail_pwm: fading "comet trail" stage behind the 6-LED flow generator.
// A lit input LED is driven at full brightness. Once it goes dark, its
// brightness drops by DECAY_STEP on every decay tick, saturating at zero.
// Each channel is driven through a 255-clock PWM with a duty register that
// only reloads at the period boundary, so a period never changes mid-way.
// Enable=0 bypasses the PWM and drives the registered input pattern straight out.
// Optional feature macro: LED_TRAIL_GAMMA_EN selects a quadratic brightness curve
// for the duty reload. When it is undefined, the curve is linear.
module led_trail_pwm #(
  parameter int                    PWM_BITS   = 8,
  parameter logic [23:0]           DECAY_DIV  = 24'd1_349_999,
  parameter logic [PWM_BITS-1:0]   DECAY_STEP = 8'd64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] LED_in,
  input  logic       Enable,
  output logic [5:0] LED,
  output logic       Frame
);

  localparam logic [PWM_BITS-1:0] ZERO_B     = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] ONE_B      = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = {PWM_BITS{1'b1}};
  // The period is 255 clocks (0..254), so a duty of 255 stays high for the whole period.
  localparam logic [PWM_BITS-1:0] PWM_TOP    = BRIGHT_MAX - ONE_B;

  logic [5:0]          r_in_q;
  logic [PWM_BITS-1:0] r_bright [6];
  logic [PWM_BITS-1:0] r_duty   [6];
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [23:0]         r_decay_cnt;
  logic [5:0]          r_led;
  logic                r_frame;

  logic                w_tick;
  logic                w_wrap;
  logic [PWM_BITS-1:0] w_bright_nxt [6];
  logic [PWM_BITS-1:0] w_shaped     [6];
  logic [5:0]          w_pwm_out;

  // Brightness-to-duty curve. It is applied only when the duty register reloads.
  function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] b);
`ifdef LED_TRAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] v_sq;
    v_sq = ({{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b}) + {{PWM_BITS{1'b0}}, b};
    return v_sq[2*PWM_BITS-1:PWM_BITS];
`else
    return b;
`endif
  endfunction

  assign w_tick = (r_decay_cnt == DECAY_DIV);
  assign w_wrap = (r_pwm_cnt == PWM_TOP);

  // Per-channel next brightness (set beats decay), shaped duty and PWM compare.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_bright_nxt[i] = r_bright[i];
      if (r_in_q[i]) begin
        w_bright_nxt[i] = BRIGHT_MAX;
      end else if (w_tick) begin
        if (r_bright[i] >= DECAY_STEP) begin
          w_bright_nxt[i] = r_bright[i] - DECAY_STEP;
        end else begin
          w_bright_nxt[i] = ZERO_B;
        end
      end else begin
        w_bright_nxt[i] = r_bright[i];
      end
      w_shaped[i]  = shape(r_bright[i]);
      w_pwm_out[i] = (r_duty[i] > r_pwm_cnt);
    end
  end

  // Input register, PWM period counter and free-running decay counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_in_q      <= 6'd0;
      r_pwm_cnt   <= ZERO_B;
      r_decay_cnt <= 24'd0;
    end else begin
      r_in_q <= LED_in;
      if (w_wrap) begin
        r_pwm_cnt <= ZERO_B;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + ONE_B;
      end
      if (w_tick) begin
        r_decay_cnt <= 24'd0;
      end else begin
        r_decay_cnt <= r_decay_cnt + 24'd1;
      end
    end
  end

  // Brightness update every clock. The duty registers reload from the pre-update
  // brightness only on the 254->0 wrap.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 6; i++) begin
        r_bright[i] <= ZERO_B;
        r_duty[i]   <= ZERO_B;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        r_bright[i] <= w_bright_nxt[i];
        if (w_wrap) begin
          r_duty[i] <= w_shaped[i];
        end else begin
          r_duty[i] <= r_duty[i];
        end
      end
    end
  end

  // Registered outputs: PWM or bypass select, and the period-start pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_led   <= 6'd0;
      r_frame <= 1'b0;
    end else begin
      if (Enable) begin
        r_led <= w_pwm_out;
      end else begin
        r_led <= r_in_q;
      end
      r_frame <= (r_pwm_cnt == ZERO_B);
    end
  end

  assign LED   = r_led;
  assign Frame = r_frame;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Testbench for led_trail_pwm. It uses two instances that share their inputs:
// dut uses a decay period of 100 clocks and dut_s uses a decay period of 255
// clocks, which is aligned with the PWM period.
module tb_led_trail_pwm;

  logic       Clock  = 1'b0;
  logic       Reset  = 1'b1;
  logic [5:0] LED_in = 6'd0;
  logic       Enable = 1'b1;
  logic [5:0] LED, LED_s;
  logic       Frame, Frame_s;

  int checks = 0;
  int errors = 0;
  int h  [6];
  int hs [6];
  int hf;
  int waited;

`ifdef LED_TRAIL_GAMMA_EN
  localparam int G191 = 143;
  localparam int G127 = 63;
  localparam int G63  = 15;
`else
  localparam int G191 = 191;
  localparam int G127 = 127;
  localparam int G63  = 63;
`endif

  typedef struct {
    logic [5:0] led_in;
    logic       en;
    logic [5:0] exp_on;
  } vec_t;

  vec_t vecs [6];

  led_trail_pwm #(.PWM_BITS(8), .DECAY_DIV(24'd99), .DECAY_STEP(8'd64)) dut (
    .Clock(Clock), .Reset(Reset), .LED_in(LED_in), .Enable(Enable),
    .LED(LED), .Frame(Frame));

  led_trail_pwm #(.PWM_BITS(8), .DECAY_DIV(24'd254), .DECAY_STEP(8'd64)) dut_s (
    .Clock(Clock), .Reset(Reset), .LED_in(LED_in), .Enable(Enable),
    .LED(LED_s), .Frame(Frame_s));

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Reset for three sampled edges. The task returns on the negedge right
  // before the first edge after release.
  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      chk("reset_led", {26'd0, LED}, 32'd0);
      chk("reset_frame", {31'd0, Frame}, 32'd0);
      chk("reset_led_s", {26'd0, LED_s}, 32'd0);
    end
    Reset = 1'b0;
  endtask

  // Wait for the next Frame cycle, then count high cycles over one full period.
  task automatic count_period(output int w);
    w = 0;
    do begin
      @(negedge Clock);
      w++;
    end while (!Frame && w < 400);
    chk("frame_seen", {31'd0, Frame}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      h[i]  = 0;
      hs[i] = 0;
    end
    hf = 0;
    for (int c = 0; c < 255; c++) begin
      if (c > 0) @(negedge Clock);
      for (int i = 0; i < 6; i++) begin
        h[i]  += int'(LED[i]);
        hs[i] += int'(LED_s[i]);
      end
      hf += int'(Frame);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int exp_s [6];
    int exp_d [6];

    vecs[0] = '{6'h3F, 1'b1, 6'h3F};
    vecs[1] = '{6'h01, 1'b1, 6'h01};
    vecs[2] = '{6'h2A, 1'b1, 6'h2A};
    vecs[3] = '{6'h15, 1'b0, 6'h15};
    vecs[4] = '{6'h00, 1'b1, 6'h00};
    vecs[5] = '{6'h30, 1'b0, 6'h30};

    // Static patterns: first period after reset, then the steady state.
    for (int v = 0; v < 6; v++) begin
      LED_in = vecs[v].led_in;
      Enable = vecs[v].en;
      do_reset();
      count_period(waited);
      chk($sformatf("v%0d_first_frame_delay", v), waited, 1);
      chk($sformatf("v%0d_frames_p1", v), hf, 1);
      for (int i = 0; i < 6; i++)
        chk($sformatf("v%0d_p1_bit%0d", v, i), h[i],
            (!vecs[v].en && vecs[v].exp_on[i]) ? 254 : 0);
      count_period(waited);
      chk($sformatf("v%0d_period_len", v), waited, 1);
      for (int i = 0; i < 6; i++)
        chk($sformatf("v%0d_p2_bit%0d", v, i), h[i], vecs[v].exp_on[i] ? 255 : 0);
    end

    // Decay: bit 0 is held, then the input moves to bit 1 after edge R+299.
    LED_in = 6'b000001;
    Enable = 1'b1;
    do_reset();
    repeat (300) @(negedge Clock);
    LED_in = 6'b000010;
    exp_s = '{255, G191, G127, G63, 0, 0};
    exp_d = '{G127, 0, 0, 0, 0, 0};
    for (int p = 0; p < 6; p++) begin
      count_period(waited);
      chk($sformatf("decay_s_p%0d_bit0", p), hs[0], exp_s[p]);
      chk($sformatf("decay_d_p%0d_bit0", p), h[0], exp_d[p]);
      chk($sformatf("decay_p%0d_bit1", p), h[1], 255);
      chk($sformatf("decay_s_p%0d_bit1", p), hs[1], 255);
      chk($sformatf("decay_p%0d_frames", p), hf, 1);
    end

    // Simultaneous: in_q[2] is high exactly in the tick cycle before edge R+199.
    LED_in = 6'b000000;
    Enable = 1'b1;
    do_reset();
    repeat (198) @(negedge Clock);
    LED_in = 6'b000100;
    @(negedge Clock);
    LED_in = 6'b000000;
    count_period(waited);
    chk("simul_wait", waited, 57);
    chk("simul_bit2_p1", h[2], 255);
    chk("simul_bit0_p1", h[0], 0);
    count_period(waited);
    chk("simul_bit2_p2", h[2], G63);

    // Bypass latency, no toggling, then resumption from the current duty.
    LED_in = 6'b000001;
    Enable = 1'b0;
    do_reset();
    repeat (300) @(negedge Clock);
    LED_in = 6'b000100;
    @(negedge Clock);
    chk("bypass_lat1", {26'd0, LED}, 32'd1);
    @(negedge Clock);
    chk("bypass_lat2", {26'd0, LED}, 32'd4);
    bad = 0;
    for (int c = 0; c < 98; c++) begin
      @(negedge Clock);
      if (LED !== 6'b000100) bad++;
    end
    chk("bypass_steady", bad, 0);
    Enable = 1'b1;
    @(negedge Clock);
    chk("resume_first", {26'd0, LED}, 32'd1);
    count_period(waited);
    chk("resume_wait", waited, 110);
    chk("gamma_bit0", h[0], G127);
    chk("resume_bit2", h[2], 255);
    chk("resume_bit1", h[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream stage of the 6-LED flow generator. Consumes its 6-bit one-hot LED pattern and drives the physical LEDs through per-channel PWM. The effect is a fading "comet trail": a lit LED is full brightness, and each LED that goes dark dims in steps instead of switching off. Sits between the flow generator output and the board LED pins, in the same 27 MHz domain.

## Interface
- `PWM_BITS`, default 8: brightness and PWM counter width. The block is specified for 8 only.
- `DECAY_DIV`, default 24'd1_349_999: decay tick period minus one, in clocks (50 ms at 27 MHz).
- `DECAY_STEP`, default 8'd64: brightness subtracted per decay tick.
- `Clock`  in  1: 27 MHz system clock.
- `Reset`  in  1: synchronous, active-high reset.
- `LED_in`  in  6: pattern from the flow stage; level-sensitive, high = LED lit.
- `Enable`  in  1: 1 = trail/PWM mode; 0 = bypass.
- `LED`  out  6: registered PWM output; high = LED on.
- `Frame`  out  1: registered one-cycle pulse at the start of each PWM period.

## Operation
- Input stage: `LED_in` is registered once into `in_q`.
- Brightness registers `bright[i]` (8 bit), updated every clock with this priority:
  - If `in_q[i]`=1: `bright[i]` is set to 255.
  - Else, on a decay tick: `bright[i]` becomes `bright[i]-DECAY_STEP` if `bright[i]` ≥ `DECAY_STEP`, otherwise 0 (saturating, never wraps).
  - Otherwise it holds.
- Decay counter: counts 0..`DECAY_DIV`, then returns to 0. The tick asserts for one cycle when the count equals `DECAY_DIV`. It runs regardless of `Enable`.
- PWM counter `pwm_cnt`: counts 0..254 and wraps, giving a 255-clock period (~105.9 kHz).
- Shadow duty `duty[i]`: loaded from `f(bright[i])` only on the edge where `pwm_cnt` goes 254→0. This prevents mid-period glitches.
- Output when `Enable`=1: `LED[i]` <= (`duty[i]` > `pwm_cnt`). Duty 255 gives constantly on; duty 0 gives constantly off; duty d gives d high cycles per period.
- Output when `Enable`=0: `LED` <= `in_q` (bypass). Brightness, counters and shadow keep running, so returning to `Enable`=1 needs no warm-up.
- `Frame` <= (`pwm_cnt`==0).
- Simultaneous events:
  - `in_q[i]`=1 on a tick: set wins, result 255.
  - Shadow load on a tick edge: loads the pre-update `bright`.

## Timing
- Reset: all of the following are 0 on the edge after `Reset` is sampled high, and stay 0 while it is held:
  - `LED`=0, `Frame`=0
  - `in_q`, `bright[*]`, `duty[*]`
  - `pwm_cnt`, decay counter
- Reset mid-period aborts the period; counting restarts from 0 on the first edge after release.
- `LED_in` edge k gives `in_q` at k+1 and `bright` at k+2. The value becomes visible at the next 254→0 wrap, which is at most 255 cycles later.
- `LED` lags `pwm_cnt` by 1 cycle.
- Bypass latency: `LED_in` to `LED` is 2 cycles (`in_q` plus the output register).
- `Frame` is high during the cycle after `pwm_cnt`==0.

## Configuration
- `LED_TRAIL_GAMMA_EN`
  - Defined: `f(b)` = (b*b + b) >> 8, computed with a 16-bit intermediate. This maps 0→0, 64→16, 127→63, 128→64, 255→255.
  - Undefined: `f(b)` = b (linear).
  - Affects only the shadow load; the bypass path is unaffected.

## Test plan
All tests use `DECAY_DIV`=99 and `DECAY_STEP`=64, unless stated otherwise.
1. Reset mid-run: `LED_in`=6'h3F, `Enable`=1, then `Reset` high for 3 cycles. Expect `LED`=0 and `Frame`=0 from the edge after the first sampled reset. After release, the first `Frame` pulse appears 1 cycle later and all `LED` bits are high continuously from the second period.
2. Full on: hold `LED_in`=6'b000001. Expect `LED[0]` high 255/255 cycles per period and `LED[5:1]`=0.
3. Decay: hold bit 0 high, then switch `LED_in`=6'b000010. Measured `LED[0]` high counts per period after successive ticks must be 191, 127, 63, 0, and stay 0 (saturation, no wrap to 255).
4. Simultaneous: `LED_in[2]` pulses high exactly on the decay-tick cycle. Expect `bright[2]`=255 and a 255/255 duty in the following period.
5. Bypass: `Enable`=0, `LED_in` steps 6'b000001→6'b000100. Expect `LED` to follow exactly 2 cycles later with no PWM toggling. Restore `Enable`=1: PWM output resumes on the next cycle using the current shadow.
6. Gamma: `bright[0]`=127. With `LED_TRAIL_GAMMA_EN` defined, expect 63 high cycles per period; without it, 127 high cycles.
